// File: rtl/minc_loader.sv
// Program loader for the minc core: assembles a framed byte stream into instruction
// words, writes them to the core's ROM and releases the core once the checksum passes.
module minc_loader #(
    parameter int unsigned INSTR_W = 15,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               load_req,
    output logic               rom_we,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [INSTR_W-1:0] rom_wdata,
    output logic               cpu_nreset,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_cause
);

    localparam int unsigned HI_W     = INSTR_W - 8;
    localparam int unsigned REM_W    = ADDR_W + 1;
    localparam int unsigned TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [2:0] S_COUNT = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_SUM   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]         r_state,     w_state_nxt;
    logic [7:0]         r_sum,       w_sum_nxt;
    logic [REM_W-1:0]   r_rem,       w_rem_nxt;
    logic [ADDR_W-1:0]  r_waddr,     w_waddr_nxt;
    logic [HI_W-1:0]    r_hi,        w_hi_nxt;
    logic [TMR_W-1:0]   r_timer,     w_timer_nxt;
    logic [1:0]         r_err_cause, w_cause_nxt;
    logic               r_rom_we,    w_we_nxt;
    logic [ADDR_W-1:0]  r_rom_addr,  w_addr_nxt;
    logic [INSTR_W-1:0] r_rom_wdata, w_wdata_nxt;
    logic               r_rx_ready;
    logic               r_cpu_nreset;
    logic               r_done;
    logic               r_error;

    logic               w_accept;
    logic               w_timeout;
    logic [7:0]         w_sum_add;

    assign w_accept  = rx_valid & r_rx_ready;
    assign w_timeout = (TIMEOUT != 0) && (r_timer == TMR_W'(TMO_LAST));
    assign w_sum_add = r_sum + rx_data;

    // Next-state and datapath decode; an accepted byte always takes priority over a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_rem_nxt   = r_rem;
        w_waddr_nxt = r_waddr;
        w_hi_nxt    = r_hi;
        w_timer_nxt = r_timer;
        w_cause_nxt = r_err_cause;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_rom_addr;
        w_wdata_nxt = r_rom_wdata;
        case (r_state)
            S_COUNT: begin
                if (w_accept) begin
                    w_rem_nxt   = (rx_data == 8'd0) ? REM_W'(1 << ADDR_W) : REM_W'(rx_data);
                    w_waddr_nxt = '0;
                    w_sum_nxt   = rx_data;
                    w_timer_nxt = '0;
                    w_state_nxt = S_HI;
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_timer_nxt = '0;
                    if (|rx_data[7:HI_W]) begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'b01;
                    end else begin
                        w_hi_nxt    = rx_data[HI_W-1:0];
                        w_sum_nxt   = w_sum_add;
                        w_state_nxt = S_LO;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_cause_nxt = 2'b11;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_LO: begin
                if (w_accept) begin
                    w_timer_nxt = '0;
                    w_sum_nxt   = w_sum_add;
                    w_rem_nxt   = r_rem - REM_W'(1);
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_waddr;
                    w_wdata_nxt = {r_hi, rx_data};
                    w_waddr_nxt = r_waddr + ADDR_W'(1);
                    w_state_nxt = (r_rem == REM_W'(1)) ? S_SUM : S_HI;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_cause_nxt = 2'b11;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_SUM: begin
                if (w_accept) begin
                    w_timer_nxt = '0;
                    if (w_sum_add == 8'd0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_cause_nxt = 2'b10;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_cause_nxt = 2'b11;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_RUN, S_ERR: begin
                if (load_req) begin
                    w_state_nxt = S_COUNT;
                    w_sum_nxt   = '0;
                    w_waddr_nxt = '0;
                    w_cause_nxt = 2'b00;
                    w_timer_nxt = '0;
                end
            end
            default: w_state_nxt = S_COUNT;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the transition.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= S_COUNT;
            r_sum        <= '0;
            r_rem        <= '0;
            r_waddr      <= '0;
            r_hi         <= '0;
            r_timer      <= '0;
            r_err_cause  <= 2'b00;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_wdata  <= '0;
            r_rx_ready   <= 1'b1;
            r_cpu_nreset <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sum        <= w_sum_nxt;
            r_rem        <= w_rem_nxt;
            r_waddr      <= w_waddr_nxt;
            r_hi         <= w_hi_nxt;
            r_timer      <= w_timer_nxt;
            r_err_cause  <= w_cause_nxt;
            r_rom_we     <= w_we_nxt;
            r_rom_addr   <= w_addr_nxt;
            r_rom_wdata  <= w_wdata_nxt;
            r_rx_ready   <= (w_state_nxt != S_RUN) && (w_state_nxt != S_ERR);
            r_cpu_nreset <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_RUN);
            r_error      <= (w_state_nxt == S_ERR);
        end
    end

    assign rx_ready   = r_rx_ready;
    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_wdata  = r_rom_wdata;
    assign cpu_nreset = r_cpu_nreset;
    assign done       = r_done;
    assign error      = r_error;
    assign err_cause  = r_err_cause;

endmodule

// File: tb/tb_minc_loader.sv
// Bench for minc_loader: frame table plus hand-written timeout, ROM-wrap and reset
// sequences; ROM writes are checked against a queue filled by a frame model.
module tb_minc_loader;

    localparam int unsigned INSTR_W = 15;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [7:0]  addr;
        logic [14:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] b [8];
        int         len;
        logic       exp_done;
        logic       exp_err;
        logic [1:0] exp_cause;
        int         exp_writes;
    } vec_t;

    logic               CLK;
    logic               nRESET;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               load_req;
    logic               rom_we;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_wdata;
    logic               cpu_nreset;
    logic               done;
    logic               error;
    logic [1:0]         err_cause;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_wr     = 0;
    wr_t exp_q[$];

    int         m_pos;
    int         m_words;
    int         m_addr;
    logic [7:0] m_hi;

    vec_t vecs[5];

    minc_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRESET(nRESET), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .load_req(load_req), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .cpu_nreset(cpu_nreset), .done(done), .error(error),
        .err_cause(err_cause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ROM write must match the oldest expected word.
    always @(negedge CLK) begin
        if (nRESET && rom_we) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rom_unexpected: got write addr 0x%0h data 0x%0h expected none", rom_addr, rom_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rom_addr", 32'(rom_addr), 32'(e.addr));
                check("rom_wdata", 32'(rom_wdata), 32'(e.data));
            end
        end
    end

    task automatic frame_start();
        m_pos  = 0;
        m_addr = 0;
        m_words = 0;
    endtask

    // Frame model: called once per accepted byte.
    task automatic model_byte(input logic [7:0] b);
        wr_t w;
        if (m_pos == 0) begin
            m_words = (b == 8'd0) ? 256 : int'(b);
        end else if (m_pos <= 2 * m_words) begin
            if ((m_pos % 2) == 1) begin
                m_hi = b;
            end else begin
                w.addr = 8'(m_addr);
                w.data = {m_hi[6:0], b};
                exp_q.push_back(w);
                m_addr++;
            end
        end
        m_pos++;
    endtask

    // Offers one byte until accepted; returns at the falling edge after the accept edge.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int cyc;
        int idle;
        bit acc;
        cyc  = 0;
        idle = 0;
        acc  = 1'b0;
        rx_data = b;
        while (!acc) begin
            if (rnd && idle < 3 && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                idle++;
            end else begin
                rx_valid = 1'b1;
                idle = 0;
            end
            acc = rx_valid && rx_ready;
            if (acc) model_byte(b);
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            if (!acc && cyc > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: byte 0x%0h not taken in %0d cycles, expected accept", b, cyc);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        load_req = 1'b0;
    endtask

    task automatic wait_cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int         k;
        int         wr0;
        int         acc_cnt;
        logic [7:0] bq[$];
        logic [7:0] s;
        logic [7:0] hb;
        logic [7:0] lb;

        nRESET = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;

        vecs[0].b = '{8'h02, 8'h12, 8'h34, 8'h20, 8'h05, 8'h93, 8'h00, 8'h00};
        vecs[0].len = 6; vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0; vecs[0].exp_cause = 2'b00; vecs[0].exp_writes = 2;
        vecs[1].b = '{8'h02, 8'h12, 8'h34, 8'h20, 8'h05, 8'h94, 8'h00, 8'h00};
        vecs[1].len = 6; vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1; vecs[1].exp_cause = 2'b10; vecs[1].exp_writes = 2;
        vecs[2].b = '{8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].len = 2; vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1; vecs[2].exp_cause = 2'b01; vecs[2].exp_writes = 0;
        vecs[3].b = '{8'h01, 8'h7F, 8'hFF, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].len = 4; vecs[3].exp_done = 1'b1; vecs[3].exp_err = 1'b0; vecs[3].exp_cause = 2'b00; vecs[3].exp_writes = 1;
        vecs[4].b = '{8'h03, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'h01, 8'h01, 8'h7D};
        vecs[4].len = 8; vecs[4].exp_done = 1'b1; vecs[4].exp_err = 1'b0; vecs[4].exp_cause = 2'b00; vecs[4].exp_writes = 3;

        repeat (3) @(negedge CLK);
        check("rst_cpu_nreset", 32'(cpu_nreset), 0);
        check("rst_rom_we", 32'(rom_we), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_rom_wdata", 32'(rom_wdata), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_err_cause", 32'(err_cause), 0);
        check("rst_rx_ready", 32'(rx_ready), 1);
        nRESET = 1'b1;
        wait_cycle();

        // Frame table.
        for (int v = 0; v < 5; v++) begin
            frame_start();
            wr0 = n_wr;
            for (int i = 0; i < vecs[v].len; i++) begin
                if (i == vecs[v].len - 1) check("nreset_held", 32'(cpu_nreset), 0);
                send_byte(vecs[v].b[i], 1'b0);
            end
            check("vec_done", 32'(done), 32'(vecs[v].exp_done));
            check("vec_cpu_nreset", 32'(cpu_nreset), 32'(vecs[v].exp_done));
            check("vec_error", 32'(error), 32'(vecs[v].exp_err));
            check("vec_err_cause", 32'(err_cause), 32'(vecs[v].exp_cause));
            check("vec_rx_ready", 32'(rx_ready), 0);
            if (v == 2) begin
                acc_cnt = 0;
                rx_data = 8'h55;
                rx_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    if (rx_ready) acc_cnt++;
                    wait_cycle();
                end
                rx_valid = 1'b0;
                check("err_no_accept", 32'(acc_cnt), 0);
            end
            wait_cycle();
            check("vec_writes", 32'(n_wr - wr0), 32'(vecs[v].exp_writes));
            check("vec_queue_empty", 32'(exp_q.size()), 0);
            pulse_load();
            check("restart_done", 32'(done), 0);
            check("restart_error", 32'(error), 0);
            check("restart_cause", 32'(err_cause), 0);
            check("restart_rx_ready", 32'(rx_ready), 1);
        end

        // Timeout: ERR exactly TIMEOUT idle cycles after the last accept.
        frame_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        k = 0;
        while (!error && k < 40) begin
            wait_cycle();
            k++;
        end
        check("timeout_cycles", 32'(k), 32'(TIMEOUT));
        check("timeout_cause", 32'(err_cause), 32'h3);
        check("timeout_cpu_nreset", 32'(cpu_nreset), 0);
        pulse_load();
        frame_start();
        for (int i = 0; i < vecs[0].len; i++) send_byte(vecs[0].b[i], 1'b0);
        check("after_timeout_done", 32'(done), 1);
        wait_cycle();
        check("after_timeout_queue", 32'(exp_q.size()), 0);
        pulse_load();

        // Full ROM: 256 words, randomly gapped rx_valid.
        frame_start();
        bq.delete();
        bq.push_back(8'h00);
        s = 8'h00;
        for (int w = 0; w < 256; w++) begin
            hb = 8'($urandom_range(0, 127));
            lb = 8'($urandom_range(0, 255));
            bq.push_back(hb);
            bq.push_back(lb);
            s = s + hb + lb;
        end
        bq.push_back(8'(-s));
        wr0 = n_wr;
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        check("wrap_done", 32'(done), 1);
        repeat (3) wait_cycle();
        check("wrap_writes", 32'(n_wr - wr0), 256);
        check("wrap_queue", 32'(exp_q.size()), 0);
        pulse_load();

        // Reset while in LO, then a clean reload from address 0.
        frame_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h20, 1'b0);
        nRESET = 1'b0;
        #1;
        check("midrst_cpu_nreset", 32'(cpu_nreset), 0);
        check("midrst_rom_we", 32'(rom_we), 0);
        check("midrst_rom_addr", 32'(rom_addr), 0);
        check("midrst_rx_ready", 32'(rx_ready), 1);
        exp_q.delete();
        @(negedge CLK);
        nRESET = 1'b1;
        wait_cycle();
        frame_start();
        wr0 = n_wr;
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        pulse_load();
        send_byte(8'h34, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h93, 1'b0);
        check("reload_done", 32'(done), 1);
        check("reload_cpu_nreset", 32'(cpu_nreset), 1);
        wait_cycle();
        check("reload_writes", 32'(n_wr - wr0), 2);
        check("reload_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minc_loader.md
Name: minc_loader

Overview:
Program loader that sits directly upstream of the minc core. It receives a framed byte stream from a serial receiver and assembles the bytes into 15-bit instruction words. Each word goes out on a ROM write port to the core's instruction ROM. The loader holds the core in reset until a complete frame passes its checksum, then releases it.

Parameters:
INSTR_W, 15, instruction word width (high byte supplies bits [14:8], so bits 7 and up of the high byte are checked)
ADDR_W, 8, ROM address width; a frame holds at most 2**ADDR_W words
TIMEOUT, 1000000, max idle cycles between bytes inside a frame; 0 disables the timeout

Ports:
CLK  in  1  clock
nRESET  in  1  asynchronous active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte this cycle
load_req  in  1  single-cycle pulse: restart loading (honoured only in RUN/ERR)
rom_we  out  1  ROM write strobe, one cycle per word
rom_addr  out  ADDR_W  ROM write address
rom_wdata  out  INSTR_W  ROM write data
cpu_nreset  out  1  drives the core's nRESET; 0 holds the core in reset
done  out  1  frame loaded, core running
error  out  1  load failed
err_cause  out  2  01 bad high byte, 10 checksum mismatch, 11 timeout, 00 none

Behaviour:
- Reset (async): state=COUNT, cpu_nreset=0, rom_we=0, rom_addr=0, rom_wdata=0, done=0, error=0, err_cause=00, sum=0, timer=0.
- Byte acceptance: a byte is accepted on a rising edge where rx_valid&rx_ready=1. rx_ready=1 in COUNT/HI/LO/SUM and 0 in RUN/ERR. It is a registered decode of the state, with no combinational path from rx_valid.
- Frame format: count byte N (0 means 2**ADDR_W words), then N×{high byte, low byte}, then a checksum byte. The 8-bit modular sum of all bytes in the frame, including the checksum, must equal 0.
- COUNT: on accept, latch remaining=N (0 maps to 2**ADDR_W), word address=0, sum=byte, then go to HI. No timeout in this state.
- HI: on accept, if byte[7:INSTR_W-8] is non-zero, go to ERR with cause 01. Otherwise latch the byte, sum+=byte, go to LO.
- LO: on accept, sum+=byte, decrement remaining. On the next cycle, rom_we=1 for exactly one cycle, with rom_addr=word address and rom_wdata={hi[6:0],lo}. Word address then increments and wraps modulo 2**ADDR_W. Next state is SUM if remaining reaches 0, otherwise HI.
- SUM: on accept, if (sum+byte) mod 256 == 0, go to RUN; otherwise go to ERR with cause 10.
- RUN: cpu_nreset=1 and done=1, both registered and asserted in the first cycle after the checksum is accepted.
- ERR: error=1, cpu_nreset stays 0, done=0.
- Restart: a load_req pulse in RUN or ERR moves to COUNT on the next edge. In that cycle cpu_nreset, done, error and err_cause clear, and sum and word address reset to 0. load_req in any other state is ignored.
- Timeout: timer clears on every accepted byte and on entry to HI. In HI/LO/SUM it increments each cycle with no accept. When it reaches TIMEOUT-1, go to ERR with cause 11. If an accept and the timeout fall in the same cycle, the accept wins.
- Write/receive overlap: the rom_we cycle overlaps HI. A new high byte may be accepted in that same cycle, so there is no stall.
- Earlier writes: ROM words already written are not rolled back on error.
- Mid-frame reset: nRESET low at any point returns everything to its reset values immediately, including cpu_nreset=0.

Test Plan:
- Good frame: bytes 02,12,34,20,05,93 with rx_valid held high → rom_we pulses with addr0=0x1234 and addr1=0x2005. cpu_nreset=1 and done=1 one cycle after 0x93 is accepted; rx_ready=0 afterwards.
- Bad checksum: same frame with final byte 0x94 → exactly two ROM writes, then error=1, err_cause=10, cpu_nreset stays 0.
- Bad high byte: 01,80 → error=1, err_cause=01, no rom_we, remaining bytes are not accepted.
- Timeout: TIMEOUT=16, send 01,12 then stop → ERR with cause 11 exactly 16 idle cycles after the 0x12 accept. Then send load_req and a good frame → done=1.
- Full ROM wrap: N=00 followed by 256 words → 256 writes to addresses 0..255 and no write to a 257th address. rx_valid is toggled randomly throughout and every byte is taken exactly once.
- Reset mid-frame: assert nRESET low during LO → cpu_nreset=0, rom_we=0, state COUNT. A following frame loads correctly from address 0.
